// File: rtl/ttt_processor_array.sv
// NUM_PROCESSORS good/bad token threshold units sharing one programming port; TICK sweeps one unit/cycle, events registered.
// Instructions land on the accepting edge; ignored while busy. Optional macro TTT_ARRAY_SATURATE_EN saturates token arithmetic.
module ttt_processor_array #(
  parameter int NUM_PROCESSORS = 4,
  parameter int ADDR_BITS      = $clog2(NUM_PROCESSORS),
  parameter int NEW_TOKEN_BITS = 4,
  parameter int TOKEN_BITS     = 8,
  parameter int DURATION_BITS  = 8,
  parameter int DATA_BITS      = 8
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             enable,
  input  logic [3:0]                       instruction,
  input  logic [ADDR_BITS-1:0]             proc_addr,
  input  logic signed [NEW_TOKEN_BITS-1:0] good_tokens_in,
  input  logic signed [NEW_TOKEN_BITS-1:0] bad_tokens_in,
  input  logic [DATA_BITS-1:0]             data_in,
  output logic [DATA_BITS-1:0]             data_out,
  output logic                             busy,
  output logic                             token_valid,
  output logic                             token_start,
  output logic                             token_stop,
  output logic [ADDR_BITS-1:0]             token_proc
);
  localparam int XW = TOKEN_BITS + 2;
  typedef logic signed [TOKEN_BITS-1:0] tok_t;
  typedef logic signed [XW-1:0]         xtok_t;
  typedef logic [DURATION_BITS-1:0]     dur_t;

`ifdef TTT_ARRAY_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  localparam xtok_t TOK_MAX = xtok_t'((2 ** (TOKEN_BITS - 1)) - 1);
  localparam xtok_t TOK_MIN = xtok_t'(-(2 ** (TOKEN_BITS - 1)));
  localparam logic [ADDR_BITS:0]   NUM_P    = (ADDR_BITS + 1)'(NUM_PROCESSORS);
  localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(NUM_PROCESSORS - 1);

  localparam logic [3:0] OP_ADD_GOOD = 4'h0, OP_ADD_BAD = 4'h1, OP_SET_GOOD = 4'h2, OP_GET_GOOD = 4'h3;
  localparam logic [3:0] OP_SET_BAD  = 4'h4, OP_GET_BAD = 4'h5, OP_SET_REM  = 4'h6, OP_GET_REM  = 4'h7;
  localparam logic [3:0] OP_TICK     = 4'h8, OP_SET_GTH = 4'hA, OP_GET_GTH  = 4'hB;
  localparam logic [3:0] OP_SET_BTH  = 4'hC, OP_GET_BTH = 4'hD, OP_SET_DUR  = 4'hE, OP_GET_DUR  = 4'hF;

  // Wide intermediate result folded back to TOKEN_BITS: clamp or plain truncation (wrap).
  function automatic tok_t fit(input xtok_t v);
    if (SAT_EN && v > TOK_MAX) return tok_t'(TOK_MAX);
    if (SAT_EN && v < TOK_MIN) return tok_t'(TOK_MIN);
    return tok_t'(v);
  endfunction

  typedef enum logic {IDLE, SWEEP} state_t;
  state_t state, state_nxt;

  tok_t good_cnt [NUM_PROCESSORS];
  tok_t bad_cnt  [NUM_PROCESSORS];
  tok_t good_thr [NUM_PROCESSORS];
  tok_t bad_thr  [NUM_PROCESSORS];
  dur_t duration [NUM_PROCESSORS];
  dur_t remaining[NUM_PROCESSORS];
  logic [NUM_PROCESSORS-1:0] is_on;
  logic [ADDR_BITS-1:0]      sweep_idx;

  logic sweeping, accept, is_tick, addr_ok;
  logic ev_stop, ev_dec, ev_start;
  tok_t wr_tok, add_good, add_bad, rebase_good, rebase_bad;
  tok_t cur_good, cur_bad;
  dur_t wr_dur, cur_rem, cur_dur;

  assign sweeping = (state == SWEEP);
  assign busy     = sweeping;
  assign accept   = enable && (state == IDLE);
  assign is_tick  = (instruction == OP_TICK);
  assign addr_ok  = ({1'b0, proc_addr} < NUM_P);
  assign wr_tok   = $signed(data_in[TOKEN_BITS-1:0]);
  assign wr_dur   = data_in[DURATION_BITS-1:0];

  assign add_good    = fit(xtok_t'(good_cnt[proc_addr]) + xtok_t'(good_tokens_in));
  assign add_bad     = fit(xtok_t'(bad_cnt[proc_addr]) + xtok_t'(bad_tokens_in));
  // Counts are stored relative to the threshold, so moving the threshold shifts the count.
  assign rebase_good = fit(xtok_t'(good_cnt[proc_addr]) + xtok_t'(good_thr[proc_addr]) - xtok_t'(wr_tok));
  assign rebase_bad  = fit(xtok_t'(bad_cnt[proc_addr]) + xtok_t'(bad_thr[proc_addr]) - xtok_t'(wr_tok));

  assign cur_good = good_cnt[sweep_idx];
  assign cur_bad  = bad_cnt[sweep_idx];
  assign cur_rem  = remaining[sweep_idx];
  assign cur_dur  = duration[sweep_idx];

  // remaining==0 while on only arises from a wrapped duration; treat it as expiring.
  assign ev_stop  = sweeping && is_on[sweep_idx] &&
                    ((!cur_bad[TOKEN_BITS-1] && cur_bad != '0) || cur_rem <= dur_t'(1));
  assign ev_dec   = sweeping && is_on[sweep_idx] && !ev_stop;
  assign ev_start = sweeping && !is_on[sweep_idx] && !cur_good[TOKEN_BITS-1] &&
                    (cur_bad[TOKEN_BITS-1] || cur_bad == '0) && cur_dur != '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && is_tick) state_nxt = SWEEP;
      SWEEP:   if (sweep_idx == LAST_IDX) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PROCESSORS; i++) begin
        good_cnt[i]  <= '0;
        bad_cnt[i]   <= '0;
        good_thr[i]  <= '0;
        bad_thr[i]   <= '0;
        duration[i]  <= '0;
        remaining[i] <= '0;
      end
      is_on       <= '0;
      sweep_idx   <= '0;
      data_out    <= '0;
      token_valid <= 1'b0;
      token_start <= 1'b0;
      token_stop  <= 1'b0;
      token_proc  <= '0;
    end else begin
      token_valid <= ev_stop || ev_start;
      token_start <= ev_start;
      token_stop  <= ev_stop;
      token_proc  <= (ev_stop || ev_start) ? sweep_idx : '0;
      sweep_idx   <= sweeping ? sweep_idx + ADDR_BITS'(1) : '0;

      if (ev_stop) begin
        is_on[sweep_idx]     <= 1'b0;
        remaining[sweep_idx] <= '0;
      end else if (ev_dec) begin
        remaining[sweep_idx] <= cur_rem - dur_t'(1);
      end else if (ev_start) begin
        is_on[sweep_idx]     <= 1'b1;
        remaining[sweep_idx] <= cur_dur;
      end

      if (accept && !is_tick) begin
        if (!addr_ok) begin
          data_out <= '0;
        end else begin
          case (instruction)
            OP_ADD_GOOD: good_cnt[proc_addr] <= add_good;
            OP_ADD_BAD:  bad_cnt[proc_addr]  <= add_bad;
            OP_SET_GOOD: begin good_cnt[proc_addr] <= wr_tok; data_out <= DATA_BITS'($unsigned(wr_tok)); end
            OP_GET_GOOD: data_out <= DATA_BITS'($unsigned(good_cnt[proc_addr]));
            OP_SET_BAD:  begin bad_cnt[proc_addr] <= wr_tok; data_out <= DATA_BITS'($unsigned(wr_tok)); end
            OP_GET_BAD:  data_out <= DATA_BITS'($unsigned(bad_cnt[proc_addr]));
            OP_SET_REM: begin
              remaining[proc_addr] <= wr_dur;
              is_on[proc_addr]     <= (wr_dur != '0);
              data_out             <= DATA_BITS'(wr_dur);
            end
            OP_GET_REM:  data_out <= DATA_BITS'(remaining[proc_addr]);
            OP_SET_GTH: begin
              good_thr[proc_addr] <= wr_tok;
              good_cnt[proc_addr] <= rebase_good;
              data_out            <= DATA_BITS'($unsigned(wr_tok));
            end
            OP_GET_GTH:  data_out <= DATA_BITS'($unsigned(good_thr[proc_addr]));
            OP_SET_BTH: begin
              bad_thr[proc_addr] <= wr_tok;
              bad_cnt[proc_addr] <= rebase_bad;
              data_out           <= DATA_BITS'($unsigned(wr_tok));
            end
            OP_GET_BTH:  data_out <= DATA_BITS'($unsigned(bad_thr[proc_addr]));
            OP_SET_DUR:  begin duration[proc_addr] <= wr_dur; data_out <= DATA_BITS'(wr_dur); end
            OP_GET_DUR:  data_out <= DATA_BITS'(duration[proc_addr]);
            default: ;
          endcase
        end
      end
    end
  end
endmodule

// File: doc/ttt_processor_array.md
Name: ttt_processor_array

Overview:
- Parametrised successor to the single-channel token processor: NUM_PROCESSORS independent good/bad-token threshold units sharing one programming port and one event output.
- Per-processor state lives in register arrays, addressed by proc_addr.
- A TICK instruction launches a sequential sweep that tallies and counts down every processor, one per cycle, and emits start/stop events tagged with the processor index.

Parameters:
- NUM_PROCESSORS, 4, number of processor channels (>=2)
- ADDR_BITS, $clog2(NUM_PROCESSORS), width of proc_addr / token_proc
- NEW_TOKEN_BITS, 4, signed width of token increments
- TOKEN_BITS, 8, signed token counter and threshold width
- DURATION_BITS, 8, token duration / countdown width
- DATA_BITS, 8, programming data width (>= TOKEN_BITS, >= DURATION_BITS)

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- enable  in  1  instruction strobe
- instruction  in  4  opcode
- proc_addr  in  ADDR_BITS  target processor for non-TICK opcodes
- good_tokens_in  in  NEW_TOKEN_BITS  signed good increment
- bad_tokens_in  in  NEW_TOKEN_BITS  signed bad increment
- data_in  in  DATA_BITS  programming write data
- data_out  out  DATA_BITS  registered read/echo data
- busy  out  1  sweep in progress
- token_valid  out  1  one-cycle event strobe
- token_start  out  1  event is a start (valid with token_valid)
- token_stop  out  1  event is a stop (valid with token_valid)
- token_proc  out  ADDR_BITS  processor index of the event

Behaviour:
- Reset (async, immediate): all arrays cleared. Good/bad counts, thresholds, duration, remaining and isOn are 0. Sweep FSM -> IDLE.
- Reset outputs: data_out=0, busy=0, token_valid=0, token_start=0, token_stop=0, token_proc=0.
- Reset mid-sweep aborts the sweep with no further events.
- Instructions are accepted only when enable=1 and busy=0. Otherwise they are ignored and leave no state change.
- proc_addr >= NUM_PROCESSORS: instruction ignored, data_out=0.
- Opcodes (p = proc_addr):
  - 0000: good[p] += sext(good_tokens_in)
  - 0001: bad[p] += sext(bad_tokens_in)
  - 0010 / 0011: set / get good[p]
  - 0100 / 0101: set / get bad[p]
  - 0110: set remaining[p]; isOn[p] = (value != 0)
  - 0111: get remaining[p]
  - 1000: TICK
  - 1001: NOP
  - 1010 / 1011: set / get good threshold[p]
  - 1100 / 1101: set / get bad threshold[p]
  - 1110 / 1111: set / get duration[p]
- Set opcodes echo the written value to data_out; get opcodes load data_out. Both take effect at the accepting edge, so data_out is visible the next cycle. data_out holds otherwise. Values are zero-extended to DATA_BITS.
- Threshold write rebases the count: count <= count + old_thr - new_thr. The count therefore always reads as (tokens received - threshold).
- Arithmetic is TOKEN_BITS two's complement. It wraps unless the optional feature is enabled.
- Sweep FSM IDLE -> SWEEP:
  - TICK accepted at edge k: busy=1 from edge k.
  - Edge k+1+i evaluates processor i, for i = 0..NUM_PROCESSORS-1.
  - busy=0 at edge k+NUM_PROCESSORS. A new instruction is accepted at edge k+NUM_PROCESSORS+1 at the earliest.
- Per-processor evaluation (mutually exclusive, in priority order):
  - isOn and (bad>0 or remaining==1): isOn=0, remaining=0, stop event.
  - isOn: remaining -= 1.
  - !isOn and good>=0 and bad<=0 and duration!=0: isOn=1, remaining=duration, start event.
  - Otherwise no change.
- A processor with duration=0 never starts.
- A processor with isOn=1 and remaining=0 (duration wrapped) stops at its next evaluation.
- Events: token_valid/token_start|token_stop/token_proc are registered at that processor's evaluation edge and last exactly one cycle. They are 0 in cycles without an event.
- Token counts are never modified by the sweep.

Optional Feature:
- Macro: TTT_ARRAY_SATURATE_EN.
- Defined: token adds and threshold rebases saturate to [-2^(TOKEN_BITS-1), 2^(TOKEN_BITS-1)-1].
- Undefined: these operations wrap modulo 2^TOKEN_BITS.

Test Plan:
- Reset, get good[2] -> data_out=0; busy=0; no token_valid for 20 cycles.
- p1: set good thr=3, duration=2; add good +2 then +1; TICK -> single start event, token_proc=1, at edge k+2; other processors silent.
- Continue p1: two more TICKs -> first produces no event (remaining 2->1); second produces stop, token_proc=1; get remaining[1] -> 0.
- p3 on with remaining=5; add bad +1; TICK -> stop, token_proc=3, at edge k+4; busy high for exactly 4 cycles; an add issued while busy is ignored (get shows unchanged).
- good[0] = 127; add +1 -> -128 without macro, 127 with TTT_ARRAY_SATURATE_EN; threshold 0->10 on count 5 -> -5.
- Assert reset two cycles into a sweep -> busy and token outputs 0 immediately; no events after release.
